fb_write_scheduler: RTL and testbench

//  Owns the single write port of the frame buffer (13-bit word addr, 16-bit data, load).

---
 rtl/fb_write_scheduler.sv | 105 ++++++++++
 tb/tb_fb_write_scheduler.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/fb_write_scheduler.sv
// fb_write_scheduler: arbitrates the frame-buffer write port between a CPU store FIFO and a clear/fill engine
// Optional feature: define BLANK_ONLY_WRITE_EN to issue writes only while the scan is outside the 512x256 area.
// Ports: clk, reset_n (async, active-low); cpu_we/cpu_addr/cpu_data in, cpu_ready out (FIFO not full);
//   clear_start/clear_pattern in, clear_busy/clear_done out; vga_h/vga_v scan position in;
//   fb_write_address/fb_data_in/fb_load registered write port out; fifo_level FIFO occupancy out.
module fb_write_scheduler #(
  parameter int ADDR_W  = 13,
  parameter int WORDS   = 8192,
  parameter int FIFO_AW = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [15:0]       cpu_data,
  output logic              cpu_ready,
  input  logic              clear_start,
  input  logic [15:0]       clear_pattern,
  output logic              clear_busy,
  output logic              clear_done,
  input  logic [10:0]       vga_h,
  input  logic [10:0]       vga_v,
  output logic [ADDR_W-1:0] fb_write_address,
  output logic [15:0]       fb_data_in,
  output logic              fb_load,
  output logic [FIFO_AW:0]  fifo_level
);
  localparam int DEPTH = 1 << FIFO_AW;
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state_q, state_d;
  logic [ADDR_W:0] cnt_q, cnt_d;
  logic [15:0] pat_q, pat_d, data_q, data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic load_q, load_d, done_q, done_d;
  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [15:0] mem_data [DEPTH];
  logic [FIFO_AW-1:0] wptr_q, rptr_q;
  logic [FIFO_AW:0] level_q;
  logic slot, push, pop, clr_issue, last;
`ifdef BLANK_ONLY_WRITE_EN
  assign slot = (vga_h > 11'd511) || (vga_v > 11'd255);
`else
  logic unused_vga;
  assign unused_vga = ^{vga_h, vga_v};
  assign slot = 1'b1;
`endif
  assign cpu_ready = level_q != (FIFO_AW+1)'(DEPTH);
  assign push = cpu_we && cpu_ready;
  assign last = cnt_q == (ADDR_W+1)'(WORDS - 1);
  assign fb_write_address = addr_q;
  assign fb_data_in = data_q;
  assign fb_load = load_q;
  assign clear_done = done_q;
  assign fifo_level = level_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE && clear_start) state_d = CLEAR;
    if (state_q == CLEAR && slot && last) state_d = IDLE;
  end
  // The clear engine owns every slot while active; the CPU FIFO only drains in IDLE.
  always_comb begin
    clear_busy = state_q == CLEAR;
    clr_issue = clear_busy && slot;
    pop = !clear_busy && slot && level_q != '0;
    load_d = clr_issue || pop;
    addr_d = clr_issue ? cnt_q[ADDR_W-1:0] : pop ? mem_addr[rptr_q] : addr_q;
    data_d = clr_issue ? pat_q : pop ? mem_data[rptr_q] : data_q;
    done_d = clr_issue && last;
    cnt_d = clr_issue ? cnt_q + (ADDR_W+1)'(1) : clear_busy ? cnt_q : '0;
    pat_d = (!clear_busy && clear_start) ? clear_pattern : pat_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      pat_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      load_q <= 1'b0;
      done_q <= 1'b0;
      wptr_q <= '0;
      rptr_q <= '0;
      level_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      pat_q <= pat_d;
      addr_q <= addr_d;
      data_q <= data_d;
      load_q <= load_d;
      done_q <= done_d;
      wptr_q <= wptr_q + FIFO_AW'(push);
      rptr_q <= rptr_q + FIFO_AW'(pop);
      level_q <= level_q + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wptr_q] <= cpu_addr;
      mem_data[wptr_q] <= cpu_data;
    end
  end
endmodule

// File: tb/tb_fb_write_scheduler.sv
// tb_fb_write_scheduler: scoreboard bench for fb_write_scheduler
module tb_fb_write_scheduler;
  logic clk = 1'b0, reset_n = 1'b0, cpu_we = 1'b0, clear_start = 1'b0;
  logic [12:0] cpu_addr = '0;
  logic [15:0] cpu_data = '0, clear_pattern = '0;
  logic [10:0] vga_h = 11'd600, vga_v = 11'd0;
  logic cpu_ready, clear_busy, clear_done, fb_load;
  logic [12:0] fb_write_address;
  logic [15:0] fb_data_in;
  logic [2:0] fifo_level;
  int checks = 0, errors = 0, done_cnt = 0;
  logic [28:0] sb[$];
  logic [28:0] exp_w;
  always #5 clk = ~clk;
  fb_write_scheduler dut (
    .clk(clk), .reset_n(reset_n), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
    .cpu_ready(cpu_ready), .clear_start(clear_start), .clear_pattern(clear_pattern),
    .clear_busy(clear_busy), .clear_done(clear_done), .vga_h(vga_h), .vga_v(vga_v),
    .fb_write_address(fb_write_address), .fb_data_in(fb_data_in), .fb_load(fb_load),
    .fifo_level(fifo_level)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask
  task automatic wait_clear_end();
    int n = 0;
    while (clear_busy && n < 20000) begin
      tick();
      n++;
    end
    chk("clear_end_timeout", clear_busy, 0);
  endtask
  always @(negedge clk) begin
    if (reset_n && fb_load) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_load: got %h/%h expected none", fb_write_address, fb_data_in);
      end else begin
        exp_w = sb.pop_front();
        if ({fb_write_address, fb_data_in} !== exp_w) begin
          errors++;
          $display("FAIL load_order: got %h/%h expected %h/%h", fb_write_address, fb_data_in, exp_w[28:16], exp_w[15:0]);
        end
      end
    end
    if (reset_n && clear_done) begin
      done_cnt++;
      checks++;
      if (clear_busy !== 1'b0 || fb_load !== 1'b1 || fb_write_address !== 13'h1fff) begin
        errors++;
        $display("FAIL done_timing: got busy=%b load=%b addr=%h expected 0/1/1fff", clear_busy, fb_load, fb_write_address);
      end
    end
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
  initial begin
    repeat (3) tick();
    chk("rst_load", fb_load, 0);
    chk("rst_ready", cpu_ready, 1);
    chk("rst_level", fifo_level, 0);
    chk("rst_busy", clear_busy, 0);
    chk("rst_done", clear_done, 0);
    reset_n = 1'b1;
    tick();
    cpu_we = 1'b1; cpu_addr = 13'h0010; cpu_data = 16'hA5A5;
    sb.push_back({13'h0010, 16'hA5A5});
    tick();
    cpu_we = 1'b0;
    chk("lat_early", fb_load, 0);
    chk("lat_level", fifo_level, 1);
    tick();
    chk("lat_load", fb_load, 1);
    chk("lat_addr", fb_write_address, 13'h0010);
    chk("lat_data", fb_data_in, 16'hA5A5);
    for (int i = 0; i < 3; i++) begin
      cpu_we = 1'b1; cpu_addr = 13'(13'h0200 + i); cpu_data = 16'(16'h3300 + i);
      sb.push_back({cpu_addr, cpu_data});
      tick();
    end
    cpu_we = 1'b0;
    repeat (4) tick();
    chk("idle_burst_drained", sb.size(), 0);
    chk("hold_addr", fb_write_address, 13'h0202);
    clear_start = 1'b1; clear_pattern = 16'hFFFF;
    for (int a = 0; a < 8192; a++) sb.push_back({13'(a), 16'hFFFF});
    tick();
    clear_start = 1'b0; clear_pattern = '0;
    chk("clr_busy", clear_busy, 1);
    wait_clear_end();
    repeat (2) tick();
    chk("clr_done_pulses", done_cnt, 1);
    chk("clr_sb_empty", sb.size(), 0);
    clear_start = 1'b1; clear_pattern = 16'h1234;
    for (int a = 0; a < 8192; a++) sb.push_back({13'(a), 16'h1234});
    tick();
    for (int i = 0; i < 5; i++) begin
      cpu_we = 1'b1; cpu_addr = 13'(13'h0100 + i); cpu_data = 16'(16'hC000 + i);
      clear_start = 1'b1; clear_pattern = 16'h0000;
      chk("burst_ready", cpu_ready, i < 4);
      if (i < 4) sb.push_back({cpu_addr, cpu_data});
      tick();
    end
    cpu_we = 1'b0; clear_start = 1'b0;
    chk("full_level", fifo_level, 4);
    chk("full_ready", cpu_ready, 0);
    wait_clear_end();
    repeat (6) tick();
    chk("clr2_done_pulses", done_cnt, 2);
    chk("clr2_sb_empty", sb.size(), 0);
    chk("clr2_level", fifo_level, 0);
    clear_start = 1'b1; clear_pattern = 16'h5555;
    for (int a = 0; a < 100; a++) sb.push_back({13'(a), 16'h5555});
    tick();
    clear_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cpu_we = 1'b1; cpu_addr = 13'(13'h0300 + i); cpu_data = 16'h7777;
      tick();
    end
    cpu_we = 1'b0;
    chk("abort_pre_level", fifo_level, 2);
    begin
      int n = 0;
      do begin
        @(negedge clk);
        #1;
        n++;
      end while (!(fb_load && fb_write_address == 13'd99) && n < 300);
    end
    chk("abort_reached", fb_write_address, 13'd99);
    reset_n = 1'b0;
    #1;
    chk("abort_load", fb_load, 0);
    chk("abort_ready", cpu_ready, 1);
    chk("abort_level", fifo_level, 0);
    chk("abort_busy", clear_busy, 0);
    chk("abort_done", clear_done, 0);
    chk("abort_addr", fb_write_address, 0);
    chk("abort_sb_empty", sb.size(), 0);
    tick();
    reset_n = 1'b1;
    repeat (10) tick();
    chk("abort_no_done", done_cnt, 2);
    chk("abort_idle", clear_busy, 0);
`ifdef BLANK_ONLY_WRITE_EN
    vga_h = 11'd100; vga_v = 11'd100;
    cpu_we = 1'b1; cpu_addr = 13'h0400; cpu_data = 16'hBEEF;
    tick();
    cpu_we = 1'b0;
    repeat (5) begin
      tick();
      chk("blank_hold", fb_load, 0);
    end
    sb.push_back({13'h0400, 16'hBEEF});
    vga_h = 11'd600;
    tick();
    chk("blank_resume", fb_load, 1);
    tick();
    chk("blank_sb_empty", sb.size(), 0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
